div_operand_sequencer: RTL and testbench

- Upstream feeder for the combinational 4-bit `div` unit.
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Drives the head pair onto the divider's a/b inputs, waits a fixed settle time, then captures quotient/remainder into an output register.
- Handles divide-by-zero deterministically, so downstream logic never sees divider X/garbage.

---
 rtl/div_operand_sequencer.sv | 162 ++++++++++++++++
 tb/tb_div_operand_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_operand_sequencer.sv
// Operand FIFO + settle/capture sequencer feeding a combinational divider.
// Optional build macro DIV_DBZ_DROP_EN rejects b==0 pairs at enqueue instead of flagging them.
module div_operand_sequencer #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         div_a,
  output logic [WIDTH-1:0]         div_b,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_quotient,
  output logic [WIDTH-1:0]         out_remainder,
  output logic                     out_dbz,
`ifdef DIV_DBZ_DROP_EN
  output logic                     dbz_drop,
  output logic                     dbz_seen,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_WAIT    = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    settle_cnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];

  logic full;
  logic empty;
  logic pop;
  logic accept;
  logic write;
  logic div_by_zero;

  assign full   = (fifo_count == (AW+1)'(DEPTH));
  assign empty  = (fifo_count == '0);
  assign pop    = (state == ST_IDLE) && !empty && !out_valid;
  // A pop in this cycle frees a slot, so a full FIFO may still take a push.
  assign in_ready = !full || pop;
  assign accept   = in_valid && in_ready;
  assign div_by_zero = (div_b == '0);

`ifdef DIV_DBZ_DROP_EN
  assign write   = accept && (in_b != '0);
  assign out_dbz = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbz_drop <= 1'b0;
      dbz_seen <= 1'b0;
    end else begin
      dbz_drop <= accept && (in_b == '0);
      if (accept && (in_b == '0)) begin
        dbz_seen <= 1'b1;
      end
    end
  end
`else
  assign write = accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dbz <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      out_dbz <= div_by_zero;
    end
  end
`endif

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (write) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({write, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      settle_cnt    <= '0;
      div_a         <= '0;
      div_b         <= '0;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            div_a      <= mem_a[rd_ptr];
            div_b      <= mem_b[rd_ptr];
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == CW'(SETTLE - 1)) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          out_valid <= 1'b1;
          state     <= ST_WAIT;
          // Divider outputs are undefined for b==0; substitute a fixed result.
          if (div_by_zero) begin
            out_quotient  <= '1;
            out_remainder <= div_a;
          end else begin
            out_quotient  <= div_quotient;
            out_remainder <= div_remainder;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_operand_sequencer.sv
// Scoreboard bench for div_operand_sequencer with a behavioural 4-bit divider stub.
module tb_div_operand_sequencer;
  localparam int W = 4;
  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, in_ready, out_valid, out_ready, out_dbz;
  logic [W-1:0] in_a, in_b, div_a, div_b, div_quotient, div_remainder;
  logic [W-1:0] out_quotient, out_remainder;
  logic [$clog2(D):0] fifo_count;
`ifdef DIV_DBZ_DROP_EN
  logic dbz_drop, dbz_seen;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  // Divider stub: true division, recognisable junk for b==0.
  always_comb begin
    div_quotient  = 4'h3;
    div_remainder = 4'h6;
    if (div_b != 0) begin
      div_quotient  = div_a / div_b;
      div_remainder = div_a % div_b;
    end
  end

  div_operand_sequencer #(.WIDTH(W), .DEPTH(D), .SETTLE(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_a(div_a), .div_b(div_b),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_dbz(out_dbz),
`ifdef DIV_DBZ_DROP_EN
    .dbz_drop(dbz_drop), .dbz_seen(dbz_seen),
`endif
    .fifo_count(fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [W-1:0] r,
                      input logic dbz, input bit has_res);
    int g;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    g = 0;
    while (!in_ready && g < 200) begin
      tick();
      g++;
    end
    check("push_ready", in_ready, 1);
    if (has_res) exp_q.push_back({q, r, dbz});
    $display("push a=%0d b=%0d", a, b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 200) begin
      tick();
      g++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  // Monitor: a result is consumed at the next rising edge when valid and ready.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got q=%0d r=%0d dbz=%0d, required none",
                 out_quotient, out_remainder, out_dbz);
      end else begin
        e = exp_q.pop_front();
        $display("result q=%0d r=%0d dbz=%0d", out_quotient, out_remainder, out_dbz);
        if ({out_quotient, out_remainder, out_dbz} !== e) begin
          n_bad++;
          $display("FAIL result: got q=%0d r=%0d dbz=%0d, required q=%0d r=%0d dbz=%0d",
                   out_quotient, out_remainder, out_dbz, e[8:5], e[4:1], e[0]);
        end
      end
    end
  end

  initial begin
    int lat;
    int gap;
    int g;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_div_a", div_a, 0);
    check("rst_div_b", div_b, 0);
    check("rst_out_q", out_quotient, 0);
    check("rst_out_r", out_remainder, 0);
    check("rst_out_dbz", out_dbz, 0);
    rst = 1'b0;
    tick();

    // Basic divide and push-to-valid latency
    push(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, 4);
    drain();

    // Back-to-back results: spacing between result starts
    push(4'd15, 4'd4, 4'd3, 4'd3, 1'b0, 1);
    push(4'd14, 4'd5, 4'd2, 4'd4, 1'b0, 1);
    g = 0;
    while (!out_valid && g < 20) begin
      tick();
      g++;
    end
    tick();
    gap = 1;
    while (!out_valid && gap < 20) begin
      tick();
      gap++;
    end
    check("throughput_gap", gap, 5);
    drain();

`ifndef DIV_DBZ_DROP_EN
    push(4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 1);
    drain();
    check("hold_div_a", div_a, 9);
    check("hold_div_b", div_b, 0);
`else
    push(4'd7, 4'd0, 4'd0, 4'd0, 1'b0, 0);
    check("dbz_drop_pulse", dbz_drop, 1);
    check("dbz_seen_set", dbz_seen, 1);
    check("dbz_not_written", fifo_count, 0);
    push(4'd8, 4'd3, 4'd2, 4'd2, 1'b0, 1);
    check("dbz_drop_clear", dbz_drop, 0);
    drain();
    check("dbz_seen_sticky", dbz_seen, 1);
`endif

    // Backpressure: fill FIFO behind a stalled result
    out_ready = 1'b0;
    push(4'd1, 4'd1, 4'd1, 4'd0, 1'b0, 1);
    push(4'd2, 4'd1, 4'd2, 4'd0, 1'b0, 1);
    push(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1);
    push(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1);
    push(4'd10, 4'd4, 4'd2, 4'd2, 1'b0, 1);
    check("full_count", fifo_count, 4);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_a = 4'd11;
    in_b = 4'd3;
    tick();
    tick();
    tick();
    check("stall_in_ready", in_ready, 0);
    check("stall_count", fifo_count, 4);
    out_ready = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    check("pop_cycle_ready", in_ready, 1);
    check("pop_cycle_count", fifo_count, 4);
    exp_q.push_back({4'd3, 4'd2, 1'b0});
    $display("push a=11 b=3 (simultaneous with pop)");
    tick();
    in_valid = 1'b0;
    check("simul_push_pop_count", fifo_count, 4);
    drain();

    // Reset while a pair is settling with three more queued
    out_ready = 1'b0;
    push(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 1);
    push(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1);
    push(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1);
    push(4'd6, 4'd6, 4'd1, 4'd0, 1'b0, 1);
    out_ready = 1'b1;
    push(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 1);
    g = 0;
    while (!(div_a == 4'd12 && div_b == 4'd5) && g < 30) begin
      tick();
      g++;
    end
    check("settle_div_a", div_a, 12);
    check("settle_queued", fifo_count, 3);
    rst = 1'b1;
    tick();
    exp_q.delete();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_fifo_count", fifo_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_div_a", div_a, 0);
    check("mid_rst_div_b", div_b, 0);
    rst = 1'b0;
    tick();
    push(4'd15, 4'd3, 4'd5, 4'd0, 1'b0, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
